// File: rtl/adder_pkg.sv
// Shared types and constants for the sixteen-bit adder front end.
// The byte loader FSM states and the slot numbering live here.
package adder_pkg;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_WORD_W = 16;

  // Bit 1 of a slot picks the operand (0 = A, 1 = B). Bit 0 is the arrival
  // order within that operand (0 = first byte, 1 = second byte).
  localparam logic [1:0] SLOT_A0 = 2'd0;
  localparam logic [1:0] SLOT_A1 = 2'd1;
  localparam logic [1:0] SLOT_B0 = 2'd2;
  localparam logic [1:0] SLOT_B1 = 2'd3;

  typedef enum logic [2:0] {
    LD_A0 = 3'd0,
    LD_A1 = 3'd1,
    LD_B0 = 3'd2,
    LD_B1 = 3'd3,
    HOLD  = 3'd4
  } ld_state_t;

  function automatic logic [1:0] state_slot(input ld_state_t s);
    case (s)
      LD_A1:   state_slot = SLOT_A1;
      LD_B0:   state_slot = SLOT_B0;
      LD_B1:   state_slot = SLOT_B1;
      default: state_slot = SLOT_A0;
    endcase
  endfunction

endpackage

// File: rtl/operand_byte_loader.sv
// Builds operand pairs A/B from a byte-wide valid/ready stream and holds the
// pair with out_valid until the downstream adder's consumer takes it.
//
//   state | meaning
//   LD_A0 | waiting for first byte of A
//   LD_A1 | waiting for second byte of A
//   LD_B0 | waiting for first byte of B
//   LD_B1 | waiting for second byte of B
//   HOLD  | pair complete, out_valid high, no bytes accepted
module operand_byte_loader
  import adder_pkg::*;
#(
  parameter int BYTE_W     = DEF_BYTE_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] op_a,
  output logic [WORD_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  pair_cnt
);

  if (WORD_W != 2 * BYTE_W) begin : g_width_check
    $error("operand_byte_loader: WORD_W must equal 2*BYTE_W");
  end

  ld_state_t         state_q, state_d;
  logic [WORD_W-1:0] op_a_q, op_a_d;
  logic [WORD_W-1:0] op_b_q, op_b_d;
  logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;

  logic       byte_hs;
  logic       out_hs;
  logic [1:0] slot;
  logic       wr_hi;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign pair_cnt  = pair_cnt_q;

  assign byte_hs = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;
  assign slot    = state_slot(state_q);
  // Big-endian streams deliver the high half first, so the half select flips.
  assign wr_hi   = slot[0] ^ BIG_ENDIAN;

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    pair_cnt_d = pair_cnt_q;

    case (state_q)
      LD_A0:   if (byte_hs) state_d = LD_A1;
      LD_A1:   if (byte_hs) state_d = LD_B0;
      LD_B0:   if (byte_hs) state_d = LD_B1;
      LD_B1:   if (byte_hs) state_d = HOLD;
      HOLD:    if (out_hs)  state_d = LD_A0;
      default: state_d = LD_A0;
    endcase

    if (byte_hs && !clear) begin
      if (!slot[1]) begin
        if (wr_hi) op_a_d[WORD_W-1:BYTE_W] = in_data;
        else       op_a_d[BYTE_W-1:0]      = in_data;
      end else begin
        if (wr_hi) op_b_d[WORD_W-1:BYTE_W] = in_data;
        else       op_b_d[BYTE_W-1:0]      = in_data;
      end
    end

    if (out_hs && !clear) pair_cnt_d = pair_cnt_q + CNT_W'(1);

    // clear wins over both handshakes; the words and count keep their values.
    if (clear) state_d = LD_A0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LD_A0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

endmodule

// File: tb/tb_operand_byte_loader.sv
// Directed bench for operand_byte_loader: a little-endian and a big-endian
// instance, a vector table of pairs, and hand-written corner sequences.
module tb_operand_byte_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // little-endian instance
  logic        le_clear, le_in_valid, le_out_ready;
  logic [7:0]  le_in_data;
  logic        le_in_ready, le_out_valid;
  logic [15:0] le_op_a, le_op_b;
  logic [7:0]  le_pair_cnt;

  // big-endian instance
  logic        be_clear, be_in_valid, be_out_ready;
  logic [7:0]  be_in_data;
  logic        be_in_ready, be_out_valid;
  logic [15:0] be_op_a, be_op_b;
  logic [7:0]  be_pair_cnt;

  operand_byte_loader #(.BYTE_W(8), .WORD_W(16), .BIG_ENDIAN(1'b0), .CNT_W(8)) u_le (
    .clk(clk), .rst(rst), .clear(le_clear), .in_data(le_in_data), .in_valid(le_in_valid),
    .in_ready(le_in_ready), .op_a(le_op_a), .op_b(le_op_b), .out_valid(le_out_valid),
    .out_ready(le_out_ready), .pair_cnt(le_pair_cnt));

  operand_byte_loader #(.BYTE_W(8), .WORD_W(16), .BIG_ENDIAN(1'b1), .CNT_W(8)) u_be (
    .clk(clk), .rst(rst), .clear(be_clear), .in_data(be_in_data), .in_valid(be_in_valid),
    .in_ready(be_in_ready), .op_a(be_op_a), .op_b(be_op_b), .out_valid(be_out_valid),
    .out_ready(be_out_ready), .pair_cnt(be_pair_cnt));

  bit          sel_be;
  logic        cur_in_ready, cur_out_valid;
  logic [15:0] cur_op_a, cur_op_b, cur_sum;
  logic [7:0]  cur_cnt;

  assign cur_in_ready  = sel_be ? be_in_ready  : le_in_ready;
  assign cur_out_valid = sel_be ? be_out_valid : le_out_valid;
  assign cur_op_a      = sel_be ? be_op_a      : le_op_a;
  assign cur_op_b      = sel_be ? be_op_b      : le_op_b;
  assign cur_cnt       = sel_be ? be_pair_cnt  : le_pair_cnt;
  assign cur_sum       = cur_op_a + cur_op_b;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_cnt_le = 8'd0;
  logic [7:0] exp_cnt_be = 8'd0;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] exp_a, exp_b, exp_sum;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    if (sel_be) begin
      be_in_valid = v; be_in_data = d; be_out_ready = rdy; be_clear = clr;
    end else begin
      le_in_valid = v; le_in_data = d; le_out_ready = rdy; le_clear = clr;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    drive(1'b1, d, 1'b0, 1'b0);
    while (!cur_in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
    tick();
    drive(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic accept();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    if (sel_be) exp_cnt_be++;
    else        exp_cnt_le++;
    chk("accept_out_valid", {31'd0, cur_out_valid}, 32'd0);
    chk("accept_in_ready", {31'd0, cur_in_ready}, 32'd1);
    chk("accept_pair_cnt", {24'd0, cur_cnt}, {24'd0, sel_be ? exp_cnt_be : exp_cnt_le});
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    send_byte(v.b0);
    send_byte(v.b1);
    send_byte(v.b2);
    chk({tag, "_valid_before_b3"}, {31'd0, cur_out_valid}, 32'd0);
    send_byte(v.b3);
    chk({tag, "_out_valid"}, {31'd0, cur_out_valid}, 32'd1);
    chk({tag, "_in_ready_hold"}, {31'd0, cur_in_ready}, 32'd0);
    chk({tag, "_op_a"}, {16'd0, cur_op_a}, {16'd0, v.exp_a});
    chk({tag, "_op_b"}, {16'd0, cur_op_b}, {16'd0, v.exp_b});
    chk({tag, "_sum"}, {16'd0, cur_sum}, {16'd0, v.exp_sum});
    accept();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t le_tab[5];
    vec_t be_tab[2];
    logic [7:0] rb[4];
    logic [15:0] ea, eb;

    le_tab[0] = '{8'h70, 8'h13, 8'h85, 8'h1A, 16'h1370, 16'h1A85, 16'h2DF5};
    le_tab[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000};
    le_tab[2] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 16'hFFFF, 16'h0001, 16'h0000};
    le_tab[3] = '{8'h34, 8'h12, 8'h78, 8'h56, 16'h1234, 16'h5678, 16'h68AC};
    le_tab[4] = '{8'hAA, 8'h55, 8'h55, 8'hAA, 16'h55AA, 16'hAA55, 16'hFFFF};
    be_tab[0] = '{8'hFF, 8'hFF, 8'h00, 8'h01, 16'hFFFF, 16'h0001, 16'h0000};
    be_tab[1] = '{8'h12, 8'h34, 8'h56, 8'h78, 16'h1234, 16'h5678, 16'h68AC};

    rst = 1'b1;
    le_clear = 0; le_in_valid = 0; le_out_ready = 0; le_in_data = 0;
    be_clear = 0; be_in_valid = 0; be_out_ready = 0; be_in_data = 0;
    sel_be = 1'b0;
    #22 rst = 1'b0;
    tick();

    // reset state
    chk("rst_op_a", {16'd0, le_op_a}, 32'd0);
    chk("rst_op_b", {16'd0, le_op_b}, 32'd0);
    chk("rst_out_valid", {31'd0, le_out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, le_in_ready}, 32'd1);
    chk("rst_pair_cnt", {24'd0, le_pair_cnt}, 32'd0);

    for (int i = 0; i < 5; i++) run_vec($sformatf("le%0d", i), le_tab[i]);

    // out_ready held low in HOLD with in_valid asserted: nothing consumed
    send_byte(8'h70); send_byte(8'h13); send_byte(8'h85); send_byte(8'h1A);
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_op_a", {16'd0, le_op_a}, 32'h1370);
      chk("stall_op_b", {16'd0, le_op_b}, 32'h1A85);
      chk("stall_out_valid", {31'd0, le_out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, le_in_ready}, 32'd0);
    end
    chk("stall_cnt", {24'd0, le_pair_cnt}, {24'd0, exp_cnt_le});
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    exp_cnt_le++;
    chk("stall_release_cnt", {24'd0, le_pair_cnt}, 32'd6);
    chk("stall_release_in_ready", {31'd0, le_in_ready}, 32'd1);
    chk("stall_release_op_a", {16'd0, le_op_a}, 32'h1370);

    // big-endian instance
    sel_be = 1'b1;
    for (int i = 0; i < 2; i++) run_vec($sformatf("be%0d", i), be_tab[i]);
    sel_be = 1'b0;

    // clear together with the 3rd byte drops it and restarts at A0
    send_byte(8'h21); send_byte(8'h43);
    drive(1'b1, 8'h65, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_op_a", {16'd0, le_op_a}, 32'h4321);
    chk("clr_op_b_held", {16'd0, le_op_b}, 32'h1A85);
    chk("clr_out_valid", {31'd0, le_out_valid}, 32'd0);
    chk("clr_in_ready", {31'd0, le_in_ready}, 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    chk("clr_valid_early", {31'd0, le_out_valid}, 32'd0);
    send_byte(8'h04);
    chk("clr_new_valid", {31'd0, le_out_valid}, 32'd1);
    chk("clr_new_op_a", {16'd0, le_op_a}, 32'h0201);
    chk("clr_new_op_b", {16'd0, le_op_b}, 32'h0403);

    // clear in HOLD with out_ready high: no count, pair words kept
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clrhold_cnt", {24'd0, le_pair_cnt}, {24'd0, exp_cnt_le});
    chk("clrhold_out_valid", {31'd0, le_out_valid}, 32'd0);
    chk("clrhold_op_a", {16'd0, le_op_a}, 32'h0201);
    chk("clrhold_in_ready", {31'd0, le_in_ready}, 32'd1);

    // asynchronous reset while in LD_B1
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, le_out_valid}, 32'd0);
    chk("arst_op_a", {16'd0, le_op_a}, 32'd0);
    chk("arst_op_b", {16'd0, le_op_b}, 32'd0);
    chk("arst_cnt", {24'd0, le_pair_cnt}, 32'd0);
    chk("arst_in_ready", {31'd0, le_in_ready}, 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    exp_cnt_le = 8'd0;
    exp_cnt_be = 8'd0;
    tick();
    chk("arst_after_in_ready", {31'd0, le_in_ready}, 32'd1);
    chk("arst_after_out_valid", {31'd0, le_out_valid}, 32'd0);

    // 257 random pairs with idle gaps; count wraps to 1
    for (int p = 0; p < 257; p++) begin
      for (int k = 0; k < 4; k++) begin
        rb[k] = 8'($urandom);
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        send_byte(rb[k]);
      end
      ea = {rb[1], rb[0]};
      eb = {rb[3], rb[2]};
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        tick();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("rnd_valid", {31'd0, le_out_valid}, 32'd1);
      chk("rnd_op_a", {16'd0, le_op_a}, {16'd0, ea});
      chk("rnd_op_b", {16'd0, le_op_b}, {16'd0, eb});
      accept();
    end
    chk("rnd_final_cnt", {24'd0, le_pair_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
